// File: rtl/dense_requant_stage_pkg.sv
// -----------------------------------------------------------------------------
// dense_requant_stage_pkg
// Shared constants and the round/shift/ReLU/saturate helper used by the dense
// layer requantisation stages.
//   ACC_W_DEF / OUT_W_DEF : default accumulator and activation widths
//   ROM_W / SHIFT_FIELD_W : shift ROM word width and width of the shift field
//   round_shift_sat()     : generic requantisation arithmetic on a 32-bit
//                           working value (accumulators up to 31 bits)
// -----------------------------------------------------------------------------
package dense_requant_stage_pkg;

  localparam int ACC_W_DEF     = 24;
  localparam int OUT_W_DEF     = 16;
  localparam int ROM_W         = 16;
  localparam int SHIFT_FIELD_W = 5;
  localparam int CALC_W        = 32;

  localparam logic [ROM_W-1:0]         SHIFT_MASK = ROM_W'((1 << SHIFT_FIELD_W) - 1);
  localparam logic signed [CALC_W-1:0] CALC_ONE   = CALC_W'(1);
  localparam logic signed [CALC_W-1:0] CALC_ZERO  = CALC_W'(0);

  // Rounding arithmetic right shift, optional ReLU, then signed saturation to
  // out_w bits. The working width leaves headroom above acc_w so the
  // half-LSB rounding add can never wrap.
  function automatic logic signed [CALC_W-1:0] round_shift_sat(
    input logic signed [CALC_W-1:0] acc,
    input logic [ROM_W-1:0]         rom_word,
    input int                       acc_w,
    input int                       out_w,
    input logic                     relu
  );
    logic [ROM_W-1:0]         s;
    logic [ROM_W-1:0]         s_max;
    logic signed [CALC_W-1:0] half;
    logic signed [CALC_W-1:0] r;
    logic signed [CALC_W-1:0] lim_hi;
    logic signed [CALC_W-1:0] lim_lo;
    s_max = ROM_W'(acc_w - 1);
    // Only the low shift field is meaningful; upper ROM bits are don't-care.
    s     = rom_word & SHIFT_MASK;
    if (s > s_max) begin
      s = s_max;
    end else begin
      s = s;
    end
    if (s == ROM_W'(0)) begin
      half = CALC_ZERO;
      r    = acc;
    end else begin
      half = CALC_ONE <<< (s - ROM_W'(1));
      r    = (acc + half) >>> s;
    end
    if (relu && (r < CALC_ZERO)) begin
      r = CALC_ZERO;
    end else begin
      r = r;
    end
    lim_hi = (CALC_ONE <<< (out_w - 1)) - CALC_ONE;
    lim_lo = -lim_hi - CALC_ONE;
    if (r > lim_hi) begin
      r = lim_hi;
    end else if (r < lim_lo) begin
      r = lim_lo;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/dense_requant_stage_if.sv
// -----------------------------------------------------------------------------
// dense_requant_stage_if
// Bundles the accumulator input stream, the shift ROM port and the activation
// output stream of the requantisation stage.
//   slave  : the stage itself (consumes in_*, rom_data, out_ready)
//   master : the surrounding environment (producer, ROM, consumer)
// -----------------------------------------------------------------------------
interface dense_requant_stage_if
  import dense_requant_stage_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic signed [ACC_W-1:0] in_acc;
  logic [ADDR_W-1:0]       rom_addr;
  logic [ROM_W-1:0]        rom_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;

  modport slave (
    input  in_valid, in_acc, rom_data, out_ready,
    output in_ready, rom_addr, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_acc, rom_data, out_ready,
    input  in_ready, rom_addr, out_valid, out_data, out_last
  );

endinterface

// File: rtl/dense_requant_stage_round_sat.sv
// -----------------------------------------------------------------------------
// requant_round_sat
// Purely combinational requantisation of one accumulator value.
//   i_acc      : signed accumulator (ACC_W bits)
//   i_rom_data : raw shift ROM word, shift in the low field
//   o_data     : rounded, shifted, optionally ReLU'd, saturated result
// -----------------------------------------------------------------------------
module requant_round_sat
  import dense_requant_stage_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int RELU  = 0
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic [ROM_W-1:0]        i_rom_data,
  output logic signed [OUT_W-1:0] o_data
);

  logic signed [CALC_W-1:0] w_acc_ext;

  assign w_acc_ext = {{(CALC_W-ACC_W){i_acc[ACC_W-1]}}, i_acc};
  // Saturation guarantees the value fits OUT_W, so truncation is lossless.
  assign o_data    = OUT_W'(round_shift_sat(w_acc_ext, i_rom_data, ACC_W, OUT_W, (RELU != 0)));

endmodule

// File: rtl/dense_requant_stage.sv
// -----------------------------------------------------------------------------
// dense_requant_stage
// Requantises a stream of per-neuron accumulator sums using a per-neuron
// shift held in an external 1-cycle-latency ROM.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : in_valid/in_ready/in_acc  accumulator stream (one per neuron)
//           rom_addr/rom_data         shift ROM port
//           out_valid/out_ready/out_data/out_last  activation stream
// Pipeline: S0 accept -> S1 (ROM data aligned) -> output register.
// -----------------------------------------------------------------------------
module dense_requant_stage
  import dense_requant_stage_pkg::*;
#(
  parameter int NUM_NEURONS = 128,
  parameter int ADDR_W      = 7,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int RELU        = 0
) (
  input logic                  clock,
  input logic                  reset,
  dense_requant_stage_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  logic [ADDR_W-1:0]       r_idx;
  logic                    r_s1_valid;
  logic signed [ACC_W-1:0] r_s1_acc;
  logic [ADDR_W-1:0]       r_s1_idx;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_out_last;

  logic                    w_advance1;
  logic                    w_in_ready;
  logic                    w_accept;
  logic [ADDR_W-1:0]       w_idx_next;
  logic signed [OUT_W-1:0] w_result;

  assign w_advance1 = !r_out_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_advance1;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_idx_next = (r_idx == LAST_IDX) ? ADDR_W'(0) : r_idx + ADDR_W'(1);

  // On accept the ROM fetches the new neuron's shift; otherwise it keeps
  // re-reading the S1 neuron so rom_data stays aligned through any stall.
  assign bus.rom_addr  = w_accept ? r_idx : r_s1_idx;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

  requant_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .RELU  (RELU)
  ) u_round_sat (
    .i_acc      (r_s1_acc),
    .i_rom_data (bus.rom_data),
    .o_data     (w_result)
  );

  // Neuron index counter; position in the layer is implied by beat count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx <= ADDR_W'(0);
    end else if (w_accept) begin
      r_idx <= w_idx_next;
    end
  end

  // S1 holding register: waits one cycle for the ROM to return the shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_acc   <= ACC_W'(0);
      r_s1_idx   <= ADDR_W'(0);
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_acc   <= bus.in_acc;
      r_s1_idx   <= r_idx;
    end else if (w_advance1) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Output register; data and last are frozen while the consumer stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= OUT_W'(0);
      r_out_last  <= 1'b0;
    end else if (r_s1_valid && w_advance1) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_last  <= (r_s1_idx == LAST_IDX);
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dense_requant_stage.sv
// -----------------------------------------------------------------------------
// tb_dense_requant_stage
// Drives two stage instances (RELU=0 and RELU=1) with identical stimulus and
// a registered shift ROM model each; expected results go into queues when a
// beat is accepted and are compared when the stage emits them.
// -----------------------------------------------------------------------------
module tb_dense_requant_stage;
  import dense_requant_stage_pkg::*;

  localparam int N = 128;

  typedef struct {
    logic signed [23:0] acc;
    logic [15:0]        word;
    logic signed [15:0] e0;
    logic signed [15:0] e1;
  } vec_t;

  typedef struct {
    logic signed [15:0] d;
    logic               last;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  dense_requant_stage_if #(.ADDR_W(7), .ACC_W(24), .OUT_W(16)) bus0 ();
  dense_requant_stage_if #(.ADDR_W(7), .ACC_W(24), .OUT_W(16)) bus1 ();

  dense_requant_stage #(.NUM_NEURONS(N), .ADDR_W(7), .ACC_W(24), .OUT_W(16), .RELU(0)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  dense_requant_stage #(.NUM_NEURONS(N), .ADDR_W(7), .ACC_W(24), .OUT_W(16), .RELU(1)) u_dut_relu (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  logic [15:0] rom [0:N-1];
  exp_t        q0 [$];
  exp_t        q1 [$];
  exp_t        ev0;
  exp_t        ev1;
  vec_t        vecs [16];
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_idx = 0;
  int          n_stall = 0;
  int          n_out = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;

  initial forever #5 clock = ~clock;

  // Registered 1-cycle ROM read, one model per instance.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    bus0.rom_data <= rom[bus0.rom_addr];
    bus1.rom_data <= rom[bus1.rom_addr];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: round half up via floor division, independent of the RTL helper.
  function automatic logic signed [15:0] model(input longint acc, input logic [15:0] word, input bit relu);
    longint s, den, num, q;
    logic [63:0] qv;
    s = longint'(word[4:0]);
    if (s > 23) s = 23;
    if (s == 0) begin
      q = acc;
    end else begin
      den = 64'sd1 <<< s;
      num = acc + den / 2;
      q   = num / den;
      if (num < 0 && q * den != num) q = q - 1;
    end
    if (relu && q < 0) q = 0;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    qv = q;
    return qv[15:0];
  endfunction

  // Scoreboard: pop and compare when an output handshake is about to occur.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus0.out_valid && bus0.out_ready) begin
        if (q0.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL out0_unexpected: got data %0d with empty queue", bus0.out_data);
        end else begin
          ev0 = q0.pop_front();
          chk("out0_data", bus0.out_data, ev0.d);
          chk("out0_last", bus0.out_last, ev0.last);
        end
        if (n_out == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_out++;
      end
      if (bus1.out_valid && bus1.out_ready) begin
        if (q1.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL out1_unexpected: got data %0d with empty queue", bus1.out_data);
        end else begin
          ev1 = q1.pop_front();
          chk("out1_relu_data", bus1.out_data, ev1.d);
          chk("out1_relu_last", bus1.out_last, ev1.last);
        end
      end
    end
  end

  // Present one beat (called at posedge+1); returns just after it is accepted.
  task automatic send(input logic signed [23:0] acc, input logic signed [15:0] e0, input logic signed [15:0] e1);
    int waited;
    exp_t x;
    waited = 0;
    bus0.in_valid = 1'b1; bus0.in_acc = acc;
    bus1.in_valid = 1'b1; bus1.in_acc = acc;
    @(negedge clock);
    if (!bus0.in_ready) n_stall++;
    while (!bus0.in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!bus0.in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      chk("rom_addr", bus0.rom_addr, exp_idx);
      chk("rom_addr_relu", bus1.rom_addr, exp_idx);
      x.last = (exp_idx == N - 1);
      x.d = e0; q0.push_back(x);
      x.d = e1; q1.push_back(x);
      exp_idx = (exp_idx == N - 1) ? 0 : exp_idx + 1;
    end
    @(posedge clock); #1;
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
  endtask

  task automatic send_model(input logic signed [23:0] acc);
    send(acc, model(acc, rom[exp_idx], 1'b0), model(acc, rom[exp_idx], 1'b1));
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    chk("drain_q0_empty", q0.size(), 0);
    chk("drain_q1_empty", q1.size(), 0);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    q0.delete(); q1.delete();
    exp_idx = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{24'sd1000,    16'd8,     16'sd4,      16'sd4};
    vecs[1]  = '{-24'sd1000,   16'd8,     -16'sd4,     16'sd0};
    vecs[2]  = '{24'sd8388607, 16'd5,     16'sd32767,  16'sd32767};
    vecs[3]  = '{24'sh800000,  16'd5,     16'sh8000,   16'sd0};
    vecs[4]  = '{24'sd5,       16'd0,     16'sd5,      16'sd5};
    vecs[5]  = '{-24'sd7,      16'd1,     -16'sd3,     16'sd0};
    vecs[6]  = '{24'sd3,       16'd1,     16'sd2,      16'sd2};
    vecs[7]  = '{24'sd100,     16'd31,    16'sd0,      16'sd0};
    vecs[8]  = '{24'sh800000,  16'd23,    -16'sd1,     16'sd0};
    vecs[9]  = '{24'sd8388607, 16'd23,    16'sd1,      16'sd1};
    vecs[10] = '{24'sd40,      16'hFFE4,  16'sd3,      16'sd3};
    vecs[11] = '{24'sd65534,   16'd1,     16'sd32767,  16'sd32767};
    vecs[12] = '{24'sd65536,   16'd1,     16'sd32767,  16'sd32767};
    vecs[13] = '{-24'sd65538,  16'd1,     16'sh8000,   16'sd0};
    vecs[14] = '{-24'sd1,      16'd1,     16'sd0,      16'sd0};
    vecs[15] = '{-24'sd2,      16'd2,     16'sd0,      16'sd0};

    for (int k = 0; k < N; k++) rom[k] = 16'd0;
    reset = 1'b1;
    bus0.in_valid = 1'b0; bus0.in_acc = 24'sd0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_acc = 24'sd0; bus1.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_out_data", bus0.out_data, 0);
    chk("rst_out_last", bus0.out_last, 0);
    chk("rst_rom_addr", bus0.rom_addr, 0);
    chk("rst_in_ready", bus0.in_ready, 1);
    chk("rst_relu_out_valid", bus1.out_valid, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    exp_idx = 0;

    // Single beat with two-cycle latency
    rom[0] = 16'd8;
    send(24'sd1000, 16'sd4, 16'sd4);
    @(negedge clock);
    chk("lat_n1_out_valid", bus0.out_valid, 0);
    @(negedge clock);
    chk("lat_n2_out_valid", bus0.out_valid, 1);
    chk("lat_n2_out_data", bus0.out_data, 4);
    chk("lat_n2_out_last", bus0.out_last, 0);
    drain();

    // Table-driven vectors, one neuron each starting at index 0
    for (int i = 0; i < 16; i++) rom[i] = vecs[i].word;
    do_reset();
    for (int i = 0; i < 16; i++) send(vecs[i].acc, vecs[i].e0, vecs[i].e1);
    drain();

    // 256 back-to-back beats across two layer passes
    for (int k = 0; k < N; k++) rom[k] = 16'(k % 21) | ((k % 2 == 1) ? 16'hA000 : 16'h0000);
    do_reset();
    n_out = 0; n_stall = 0;
    for (int b = 0; b < 256; b++) begin
      logic signed [23:0] a;
      a = 24'($urandom);
      if (b % 37 == 5) a = 24'sd8388607;
      if (b % 37 == 6) a = 24'sh800000;
      send_model(a);
    end
    drain();
    chk("stream_outputs", n_out, 256);
    chk("stream_one_per_cycle", last_cyc - first_cyc, 255);
    chk("stream_in_ready_stalls", n_stall, 0);

    // Backpressure: consumer stalls 5 cycles mid-stream
    do_reset();
    fork
      begin
        for (int b = 0; b < 30; b++) send_model(24'($urandom_range(0, 2000000)) - 24'sd1000000);
      end
      begin
        logic signed [15:0] held;
        held = 16'sd0;
        repeat (10) @(posedge clock);
        #1;
        bus0.out_ready = 1'b0; bus1.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clock);
          if (c == 0) held = bus0.out_data;
          else chk("stall_data_hold", bus0.out_data, held);
          chk("stall_out_valid", bus0.out_valid, 1);
          chk("stall_in_ready", bus0.in_ready, 0);
          chk("stall_rom_addr", bus0.rom_addr, (exp_idx + N - 1) % N);
        end
        @(posedge clock); #1;
        bus0.out_ready = 1'b1; bus1.out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream with a beat pending on the reset edge
    do_reset();
    for (int b = 0; b < 40; b++) send_model(24'($urandom));
    bus0.in_valid = 1'b1; bus0.in_acc = 24'sd123;
    bus1.in_valid = 1'b1; bus1.in_acc = 24'sd123;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
    q0.delete(); q1.delete();
    exp_idx = 0;
    @(negedge clock);
    chk("midrst_out_valid", bus0.out_valid, 0);
    chk("midrst_out_data", bus0.out_data, 0);
    chk("midrst_relu_out_valid", bus1.out_valid, 0);
    @(posedge clock); #1;
    for (int b = 0; b < 3; b++) send_model(24'($urandom));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
